multi_cycle_controller: RTL and testbench
=========================================

# multi_cycle_controller

Control FSM for the 16-bit multi-cycle CPU: the driving end of the ALU interface. Each cycle it issues the 3-bit ALU operation code and all datapath enables (PC, memory, IR, register file, mux selects). It consumes the ALU `zero` flag to resolve conditional branches. It sits beside the datapath; opcode/funct come from the instruction register.

## Interface
- No parameters; widths are fixed by the ISA (16-bit datapath, 3-bit ALU code).
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- opcode  in  4  IR[15:12].
- funct  in  3  IR[2:0], R-type function, equal to the ALU code.
- zero  in  1  ALU zero flag (combinational from ALU).
- alu_operation  out  3  000 zero, 001 A, 010 B, 011 ~B, 100 A+B, 101 A-B, 110 A&B, 111 A|B.
- alu_src_a  out  1  0 = PC, 1 = register A (R0).
- alu_src_b  out  2  00 = register B, 01 = constant 1, 10 = sign-extended IR[11:0].
- pc_src  out  2  00 = ALU result, 01 = jump address IR[11:0].
- pc_load  out  1  PC register enable (already includes branch decision).
- i_or_d  out  1  memory address: 0 = PC, 1 = IR[11:0].
- mem_read, mem_write, ir_write, reg_write  out  1 each  enables.
- mem_to_reg  out  1  1 = memory data register, 0 = ALU-out register.
- reg_dst  out  1  1 = Ri (IR[11:9]), 0 = R0.
- state  out  4  current state encoding, for debug/verification.

## Operation
- Moore outputs decoded from `state`. Exception: `pc_load` = pc_write | (pc_write_cond & zero).
- Unlisted outputs are 0 in every state; alu_operation defaults to 000.
- States (encoding in brackets) and asserted outputs:
  - FETCH[0]: mem_read, ir_write, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_operation=100, pc_src=00, pc_write. Next: DECODE.
  - DECODE[1]: no outputs. Next state by opcode:
    - 0000 → LD_MEM
    - 0001 → ST_MEM
    - 0010 → JMP
    - 0100 → BRZ
    - 1000 → R_EX
    - 11xx → I_EX
    - any other opcode → FETCH, with no side effects.
  - LD_MEM[2]: i_or_d=1, mem_read. Next: LD_WB.
  - LD_WB[3]: reg_write, mem_to_reg=1, reg_dst=0. Next: FETCH.
  - ST_MEM[4]: i_or_d=1, mem_write. Next: FETCH.
  - JMP[5]: pc_src=01, pc_write. Next: FETCH.
  - BRZ[6]: alu_src_a=1, alu_operation=001, pc_src=01, pc_write_cond. Next: FETCH.
  - R_EX[7]: alu_src_a=1, alu_src_b=00, alu_operation=funct. Next: FETCH if funct=000 (NOP), else R_WB.
  - R_WB[8]: reg_write, mem_to_reg=0, reg_dst=1 if funct=001 (MOVETO) else 0. Next: FETCH.
  - I_EX[9]: alu_src_a=1, alu_src_b=10, alu_operation = {1, opcode[1:0]}, i.e. ADDI/SUBI/ANDI/ORI → 100/101/110/111. Next: I_WB.
  - I_WB[10]: reg_write, mem_to_reg=0, reg_dst=0. Next: FETCH.
- Encodings 11–15 are unreachable. If entered, all outputs are 0 and next state is FETCH.
- In R_WB, funct is sampled live. The IR is stable because ir_write is asserted only in FETCH.

## Timing
- Reset: state ← FETCH asynchronously. While rst=1, every output is forced 0, including `state`-decoded enables and alu_operation=000. The `state` port itself reads 0.
- First fetch completes on the first rising edge with rst=0.
- Cycles per instruction, FETCH through the last state:
  - 4: LOAD, R-type (non-NOP), I-type.
  - 3: STORE, JUMP, BRZ, NOP.
  - 2: undefined opcode.
- `zero` is used combinationally in BRZ only. pc_load follows zero within that cycle, and the PC updates at the BRZ→FETCH edge.
- Reset asserted mid-instruction aborts it immediately. Outputs drop to 0 asynchronously, so no write completes at the next edge.
- State changes on every rising edge; there are no stall or wait inputs.

## Test plan
- Reset: rst=1 in LD_WB → state=0 and all outputs 0 without a clock edge. Release → FETCH asserts mem_read=1, ir_write=1, pc_load=1, alu_operation=100, alu_src_b=01.
- LOAD (opcode 0000) → state sequence 0,1,2,3,0. In state 3: reg_write=1, mem_to_reg=1. STORE (0001) → 0,1,4,0 with mem_write=1 only in state 4.
- BRZ (0100): with zero=1 in state 6 → pc_load=1, pc_src=01, alu_operation=001. Same with zero=0 → pc_load=0. Toggling zero within state 6 toggles pc_load combinationally.
- Sweep R-type funct 000–111 → alu_operation equals funct in state 7. funct=000 returns to FETCH after 3 cycles with no reg_write. funct=001 gives reg_dst=1 in R_WB; the others give reg_dst=0.
- I-type opcodes 1100–1111 → alu_operation 100/101/110/111 with alu_src_b=10 in state 9, then reg_write=1 in state 10. JUMP (0010) → pc_src=01, pc_load=1 in state 5.
- Undefined opcode 0011 → 0,1,0 with no write enable asserted in DECODE.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// Control FSM for the 16-bit multi-cycle CPU.
// Drives the ALU operation code and every datapath enable from the current state.
module multi_cycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic [2:0] funct,
    input  logic       zero,
    output logic [2:0] alu_operation,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_load,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        LD_MEM = 4'd2,
        LD_WB  = 4'd3,
        ST_MEM = 4'd4,
        JMP    = 4'd5,
        BRZ    = 4'd6,
        R_EX   = 4'd7,
        R_WB   = 4'd8,
        I_EX   = 4'd9,
        I_WB   = 4'd10
    } state_t;

    state_t state_q, state_d;

    logic [2:0] alu_op_c;
    logic       src_a_c;
    logic [1:0] src_b_c;
    logic [1:0] pc_src_c;
    logic       pc_write_c;
    logic       pc_write_cond_c;
    logic       i_or_d_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       mem_to_reg_c;
    logic       reg_dst_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d         = FETCH;
        alu_op_c        = 3'b000;
        src_a_c         = 1'b0;
        src_b_c         = 2'b00;
        pc_src_c        = 2'b00;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        i_or_d_c        = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        reg_write_c     = 1'b0;
        mem_to_reg_c    = 1'b0;
        reg_dst_c       = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read_c = 1'b1;
                ir_write_c = 1'b1;
                src_b_c    = 2'b01;
                alu_op_c   = 3'b100;
                pc_write_c = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                casez (opcode)
                    4'b0000: state_d = LD_MEM;
                    4'b0001: state_d = ST_MEM;
                    4'b0010: state_d = JMP;
                    4'b0100: state_d = BRZ;
                    4'b1000: state_d = R_EX;
                    4'b11??: state_d = I_EX;
                    default: state_d = FETCH;
                endcase
            end
            LD_MEM: begin
                i_or_d_c   = 1'b1;
                mem_read_c = 1'b1;
                state_d    = LD_WB;
            end
            LD_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
            end
            ST_MEM: begin
                i_or_d_c    = 1'b1;
                mem_write_c = 1'b1;
            end
            JMP: begin
                pc_src_c   = 2'b01;
                pc_write_c = 1'b1;
            end
            BRZ: begin
                src_a_c         = 1'b1;
                alu_op_c        = 3'b001;
                pc_src_c        = 2'b01;
                pc_write_cond_c = 1'b1;
            end
            R_EX: begin
                src_a_c  = 1'b1;
                alu_op_c = funct;
                state_d  = (funct == 3'b000) ? FETCH : R_WB;
            end
            R_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = (funct == 3'b001);
            end
            I_EX: begin
                src_a_c  = 1'b1;
                src_b_c  = 2'b10;
                alu_op_c = {1'b1, opcode[1:0]};
                state_d  = I_WB;
            end
            I_WB: begin
                reg_write_c = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset gates every output so an aborted write never lands on the next edge.
    assign alu_operation = rst ? 3'b000 : alu_op_c;
    assign alu_src_a     = ~rst & src_a_c;
    assign alu_src_b     = rst ? 2'b00 : src_b_c;
    assign pc_src        = rst ? 2'b00 : pc_src_c;
    assign pc_load       = ~rst & (pc_write_c | (pc_write_cond_c & zero));
    assign i_or_d        = ~rst & i_or_d_c;
    assign mem_read      = ~rst & mem_read_c;
    assign mem_write     = ~rst & mem_write_c;
    assign ir_write      = ~rst & ir_write_c;
    assign reg_write     = ~rst & reg_write_c;
    assign mem_to_reg    = ~rst & mem_to_reg_c;
    assign reg_dst       = ~rst & reg_dst_c;
    assign state         = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: instruction-path model plus
// hand-computed per-instruction expectations.
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic [2:0] funct;
    logic       zero;
    logic [2:0] alu_operation;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_load;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic [3:0] state;

    multi_cycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_operation(alu_operation), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_load(pc_load),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .state(state)
    );

    always #5 clk = ~clk;

    // Bits: [19:17] aop [16] src_a [15:14] src_b [13:12] pc_src [11] pc_load
    // [10] i_or_d [9] mrd [8] mwr [7] irw [6] rwr [5] m2r [4] rdst [3:0] state
    logic [19:0] act;
    assign act = {alu_operation, alu_src_a, alu_src_b, pc_src, pc_load,
                  i_or_d, mem_read, mem_write, ir_write, reg_write,
                  mem_to_reg, reg_dst, state};

    int tests = 0;
    int fails = 0;
    logic [19:0] obs [5];

    task automatic chkf(input string name, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, a, e);
        end
    endtask

    function automatic logic [19:0] model_out(input logic [3:0] st,
        input logic [3:0] op, input logic [2:0] fn, input logic z);
        logic [2:0] aop = 3'b000;
        logic       sa = 1'b0;
        logic [1:0] sb = 2'b00;
        logic [1:0] ps = 2'b00;
        logic       pl = 1'b0, iod = 1'b0, mr = 1'b0, mw = 1'b0;
        logic       irw = 1'b0, rw = 1'b0, m2r = 1'b0, rd = 1'b0;
        case (st)
            4'd0: begin aop = 3'b100; sb = 2'b01; mr = 1; irw = 1; pl = 1; end
            4'd2: begin iod = 1; mr = 1; end
            4'd3: begin rw = 1; m2r = 1; end
            4'd4: begin iod = 1; mw = 1; end
            4'd5: begin ps = 2'b01; pl = 1; end
            4'd6: begin sa = 1; aop = 3'b001; ps = 2'b01; pl = z; end
            4'd7: begin sa = 1; aop = fn; end
            4'd8: begin rw = 1; rd = (fn == 3'b001); end
            4'd9: begin sa = 1; sb = 2'b10; aop = {1'b1, op[1:0]}; end
            4'd10: rw = 1;
            default: ;
        endcase
        return {aop, sa, sb, ps, pl, iod, mr, mw, irw, rw, m2r, rd, st};
    endfunction

    // {length, s3, s2, s1, s0}: state walk of one instruction from FETCH.
    function automatic logic [19:0] path_of(input logic [3:0] op,
        input logic [2:0] fn);
        casez (op)
            4'b0000: return {4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
            4'b0001: return {4'd3, 4'd0, 4'd4, 4'd1, 4'd0};
            4'b0010: return {4'd3, 4'd0, 4'd5, 4'd1, 4'd0};
            4'b0100: return {4'd3, 4'd0, 4'd6, 4'd1, 4'd0};
            4'b1000: return (fn == 3'b000) ?
                            {4'd3, 4'd0, 4'd7, 4'd1, 4'd0} :
                            {4'd4, 4'd8, 4'd7, 4'd1, 4'd0};
            4'b11??: return {4'd4, 4'd10, 4'd9, 4'd1, 4'd0};
            default: return {4'd2, 4'd0, 4'd0, 4'd1, 4'd0};
        endcase
    endfunction

    logic [19:0] path = '0;
    int idx = 0;

    always @(negedge clk) begin
        automatic logic [19:0] p;
        automatic int nx;
        if (rst) begin
            chkf("reset_outputs", act, 0);
            idx <= 0;
        end else begin
            p = (idx == 0) ? path_of(opcode, funct) : path;
            chkf($sformatf("model op%0h step%0d", opcode, idx), act,
                 model_out(p[4*idx +: 4], opcode, funct, zero));
            nx = idx + 1;
            path <= p;
            idx <= (nx == int'(p[19:16])) ? 0 : nx;
        end
    end

    // Starts at posedge+1 with the DUT in FETCH; returns likewise.
    task automatic instr(input logic [3:0] op, input logic [2:0] fn,
        input logic z, input int n, input logic [19:0] seq, input bit tog);
        opcode = op;
        funct  = fn;
        zero   = z;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs[i] = act;
            chkf($sformatf("seq op%0h f%0d c%0d", op, fn, i),
                 act[3:0], seq[4*i +: 4]);
            if (tog && i == 2) begin
                #1 zero = 1'b0;
                #1 chkf("brz_toggle_lo", pc_load, 0);
                zero = 1'b1;
                #1 chkf("brz_toggle_hi", pc_load, 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        opcode = 4'd0;
        funct = 3'd0;
        zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chkf("rst_hold", act, 0);
        rst = 1'b0;

        instr(4'b0000, 3'd0, 1'b0, 4, 20'h03210, 1'b0);
        chkf("fetch_word", obs[0], 20'b100_0_01_00_1_0_1_0_1_0_0_0_0000);
        chkf("ld_wb_rw", obs[3][6], 1);
        chkf("ld_wb_m2r", obs[3][5], 1);

        instr(4'b0001, 3'd0, 1'b0, 3, 20'h00410, 1'b0);
        chkf("st_mem_write", {obs[2][8], obs[1][8], obs[0][8]}, 3'b100);

        instr(4'b0010, 3'd0, 1'b0, 3, 20'h00510, 1'b0);
        chkf("jmp_pcsrc_pcl", {obs[2][13:12], obs[2][11]}, 3'b011);

        instr(4'b0100, 3'd0, 1'b1, 3, 20'h00610, 1'b0);
        chkf("brz_z1", {obs[2][19:17], obs[2][13:12], obs[2][11]}, 6'b001_01_1);
        instr(4'b0100, 3'd0, 1'b0, 3, 20'h00610, 1'b0);
        chkf("brz_z0_pcl", obs[2][11], 0);
        instr(4'b0100, 3'd0, 1'b1, 3, 20'h00610, 1'b1);

        for (int f = 0; f < 8; f++) begin
            if (f == 0) begin
                instr(4'b1000, 3'(f), 1'b0, 3, 20'h00710, 1'b0);
                chkf("nop_no_rw", {obs[2][6], obs[1][6], obs[0][6]}, 0);
            end else begin
                instr(4'b1000, 3'(f), 1'b0, 4, 20'h08710, 1'b0);
                chkf($sformatf("r_rd f%0d", f), obs[3][4], (f == 1) ? 1 : 0);
            end
            chkf($sformatf("r_aop f%0d", f), obs[2][19:17], f);
        end

        for (int k = 0; k < 4; k++) begin
            instr(4'(12 + k), 3'd5, 1'b0, 4, 20'h0A910, 1'b0);
            chkf($sformatf("i_aop k%0d", k), obs[2][19:17], 4 + k);
            chkf($sformatf("i_srcb k%0d", k), obs[2][15:14], 2);
            chkf($sformatf("i_wb_rw k%0d", k), obs[3][6], 1);
        end

        instr(4'b0011, 3'd0, 1'b0, 2, 20'h00010, 1'b0);
        chkf("undef_no_we", {obs[1][11], obs[1][9:6]}, 0);
        instr(4'b1001, 3'd2, 1'b0, 2, 20'h00010, 1'b0);

        opcode = 4'b0000;
        funct = 3'd0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chkf("pre_rst_ld_wb", state, 3);
        rst = 1'b1;
        #1 chkf("async_rst_out", act, 0);
        @(posedge clk);
        #1 chkf("rst_held_out", act, 0);
        rst = 1'b0;
        instr(4'b0010, 3'd0, 1'b0, 3, 20'h00510, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
